core_scheduler: RTL and testbench

Per-core control FSM that sequences the shared thread datapath (ALU, register file, PC/NZP unit, LSU) through the instruction cycle. It drives the 3-bit `core_state` bus consumed by every datapath unit. It waits on the instruction fetcher and on all active threads' LSUs before advancing, and owns the block's `current_pc`. One instance sits in each core, between the fetcher/decoder and the per-thread datapaths.

---
 rtl/core_scheduler.sv | 129 ++++++++++++
 tb/tb_core_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// Per-core instruction-cycle sequencer: drives core_state for the shared thread datapath,
// gates on fetcher and per-lane LSU completion, and owns the block's shared PC.
module core_scheduler #(
    parameter int THREADS = 4,
    parameter int PC_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [3:0]                thread_count,
    input  logic                      fetch_ready,
    input  logic                      decoded_mem_read,
    input  logic                      decoded_mem_write,
    input  logic                      decoded_ret,
    input  logic [2*THREADS-1:0]      lsu_state,
    input  logic [PC_W*THREADS-1:0]   next_pc,
    output logic [2:0]                core_state,
    output logic [PC_W-1:0]           current_pc,
    output logic                      fetch_req,
    output logic [THREADS-1:0]        thread_enable,
    output logic                      done,
    output logic [15:0]               busy_cycles
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_REQUEST = 3'd3,
        S_WAIT    = 3'd4,
        S_EXECUTE = 3'd5,
        S_UPDATE  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t             state;
    logic [3:0]         active_lanes;
    logic [THREADS-1:0] launch_mask;
    logic               lanes_settled;
    logic               unused_inputs;

    // WAIT exit depends only on LSU status, so the load/store flags and upper lanes'
    // next_pc carry no decision here.
    assign unused_inputs = ^{decoded_mem_read, decoded_mem_write, next_pc};

    assign core_state = state;

    always_comb begin
        active_lanes = (thread_count > 4'(THREADS)) ? 4'(THREADS) : thread_count;
        launch_mask  = '0;
        for (int unsigned i = 0; i < THREADS; i++) begin
            launch_mask[i] = (i < 32'(active_lanes));
        end
    end

    // A lane blocks WAIT only while its LSU is REQUESTING or WAITING.
    always_comb begin
        lanes_settled = 1'b1;
        for (int unsigned i = 0; i < THREADS; i++) begin
            if (thread_enable[i] &&
                (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10)) begin
                lanes_settled = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            current_pc    <= '0;
            thread_enable <= '0;
            busy_cycles   <= '0;
            fetch_req     <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (state != S_IDLE && state != S_DONE && busy_cycles != '1) begin
                busy_cycles <= busy_cycles + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (active_lanes == 4'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            thread_enable <= launch_mask;
                            current_pc    <= '0;
                            busy_cycles   <= '0;
                            state         <= S_FETCH;
                            fetch_req     <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (fetch_ready) begin
                        state     <= S_DECODE;
                        fetch_req <= 1'b0;
                    end
                end
                S_DECODE:  state <= S_REQUEST;
                S_REQUEST: state <= S_WAIT;
                S_WAIT: begin
                    if (lanes_settled) begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: state <= S_UPDATE;
                S_UPDATE: begin
                    if (decoded_ret) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        current_pc <= next_pc[PC_W-1:0];
                        state      <= S_FETCH;
                        fetch_req  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: a stage-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_core_scheduler;

    localparam int THREADS = 4;
    localparam int PC_W    = 8;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic [3:0]              thread_count = '0;
    logic                    fetch_ready = 1'b0;
    logic                    decoded_mem_read = 1'b0;
    logic                    decoded_mem_write = 1'b0;
    logic                    decoded_ret = 1'b0;
    logic [2*THREADS-1:0]    lsu_state = '0;
    logic [PC_W*THREADS-1:0] next_pc = '0;
    logic [2:0]              core_state;
    logic [PC_W-1:0]         current_pc;
    logic                    fetch_req;
    logic [THREADS-1:0]      thread_enable;
    logic                    done;
    logic [15:0]             busy_cycles;

    core_scheduler #(.THREADS(THREADS), .PC_W(PC_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .thread_count      (thread_count),
        .fetch_ready       (fetch_ready),
        .decoded_mem_read  (decoded_mem_read),
        .decoded_mem_write (decoded_mem_write),
        .decoded_ret       (decoded_ret),
        .lsu_state         (lsu_state),
        .next_pc           (next_pc),
        .core_state        (core_state),
        .current_pc        (current_pc),
        .fetch_req         (fetch_req),
        .thread_enable     (thread_enable),
        .done              (done),
        .busy_cycles       (busy_cycles)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: stage 0 idle, 1..6 the instruction cycle in order, 7 done.
    int                 m_stage = 0;
    logic [PC_W-1:0]    m_pc = '0;
    logic [THREADS-1:0] m_en = '0;
    int                 m_busy = 0;

    function automatic logic [THREADS-1:0] lane_mask(input int n);
        int k = (n > THREADS) ? THREADS : n;
        lane_mask = '0;
        for (int i = 0; i < k; i++) lane_mask[i] = 1'b1;
    endfunction

    function automatic bit lanes_quiet();
        for (int i = 0; i < THREADS; i++) begin
            if (m_en[i] && (lsu_state[2*i +: 2] inside {2'b01, 2'b10})) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_stage <= 0;
            m_pc    <= '0;
            m_en    <= '0;
            m_busy  <= 0;
        end else if (m_stage == 0) begin
            if (start && thread_count == 4'd0) begin
                m_stage <= 7;
            end else if (start) begin
                m_en    <= lane_mask(int'(thread_count));
                m_pc    <= '0;
                m_busy  <= 0;
                m_stage <= 1;
            end
        end else if (m_stage == 7) begin
            if (!start) m_stage <= 0;
        end else begin
            if (m_busy < 65535) m_busy <= m_busy + 1;
            if (!((m_stage == 1 && !fetch_ready) || (m_stage == 4 && !lanes_quiet()))) begin
                if (m_stage < 6) begin
                    m_stage <= m_stage + 1;
                end else if (decoded_ret) begin
                    m_stage <= 7;
                end else begin
                    m_pc    <= next_pc[PC_W-1:0];
                    m_stage <= 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("model_state", core_state, m_stage);
        check("model_pc", current_pc, m_pc);
        check("model_fetch_req", fetch_req, (m_stage == 1));
        check("model_done", done, (m_stage == 7));
        check("model_enable", thread_enable, m_en);
        check("model_busy", busy_cycles, m_busy);
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        for (int i = 0; i < budget && core_state !== s; i++) @(negedge clock);
        check(name, core_state, s);
    endtask

    logic [2:0] alu_seq [9] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
    int n;

    initial begin
        #1 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("rst_state", core_state, 0);
        check("rst_pc", current_pc, 0);
        check("rst_enable", thread_enable, 0);
        check("rst_busy", busy_cycles, 0);
        check("rst_done", done, 0);
        check("rst_fetch_req", fetch_req, 0);
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_rst", core_state, 0);

        // ALU op, fetch stalls two cycles
        thread_count = 4'd4;
        next_pc      = {THREADS{8'h01}};
        start        = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            check($sformatf("alu_seq%0d", k), core_state, alu_seq[k]);
            if (k == 0) start = 1'b0;
            if (k == 2) fetch_ready = 1'b1;
            if (k == 3) fetch_ready = 1'b0;
        end
        check("alu_pc", current_pc, 8'h01);
        check("alu_busy", busy_cycles, 8);
        check("alu_enable", thread_enable, 4'hF);

        // RET with start held high
        fetch_ready = 1'b1;
        decoded_ret = 1'b1;
        start       = 1'b1;
        wait_state(3'd7, 10, "ret_done_state");
        check("ret_done_flag", done, 1);
        check("ret_busy", busy_cycles, 14);
        check("ret_pc", current_pc, 8'h01);
        repeat (3) @(negedge clock);
        check("ret_hold", core_state, 7);
        check("ret_busy_hold", busy_cycles, 14);
        start       = 1'b0;
        fetch_ready = 1'b0;
        decoded_ret = 1'b0;
        @(negedge clock);
        check("ret_idle", core_state, 0);

        // Load stall: lane 2 busy, lane 3 disabled and stuck REQUESTING
        thread_count     = 4'd3;
        decoded_mem_read = 1'b1;
        lsu_state        = 8'b01_00_00_00;
        next_pc          = {8'h33, 8'h22, 8'h11, 8'hFF};
        fetch_ready      = 1'b1;
        start            = 1'b1;
        @(negedge clock);
        check("ld_fetch", core_state, 1);
        check("ld_enable", thread_enable, 4'b0111);
        start = 1'b0;
        wait_state(3'd3, 5, "ld_request");
        lsu_state[5:4] = 2'b10;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (core_state != 3'd4) break;
            n++;
            if (n == 2) start = 1'b1;
            if (n == 3) start = 1'b0;
            if (n == 5) lsu_state[5:4] = 2'b11;
        end
        check("ld_wait_len", n, 5);
        check("ld_execute", core_state, 5);
        decoded_mem_read = 1'b0;
        @(negedge clock);
        check("ld_update", core_state, 6);
        @(negedge clock);
        check("ld_pc_ff", current_pc, 8'hFF);
        next_pc[7:0] = 8'h00;

        // Minimum instruction period and PC wrap to zero
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n++;
            if (core_state == 3'd1) break;
        end
        check("min_period", n, 6);
        check("wrap_pc", current_pc, 8'h00);
        decoded_ret = 1'b1;
        wait_state(3'd7, 10, "wrap_done");
        decoded_ret = 1'b0;
        @(negedge clock);
        check("wrap_idle", core_state, 0);

        // Zero-lane launch goes straight to DONE, enables untouched
        thread_count = 4'd0;
        start        = 1'b1;
        @(negedge clock);
        check("tc0_state", core_state, 7);
        check("tc0_done", done, 1);
        check("tc0_enable", thread_enable, 4'b0111);
        start = 1'b0;
        @(negedge clock);
        check("tc0_idle", core_state, 0);

        // Oversized lane count clamps; then hold FETCH to saturate busy_cycles
        lsu_state    = '0;
        thread_count = 4'd12;
        fetch_ready  = 1'b0;
        start        = 1'b1;
        @(negedge clock);
        check("tc12_state", core_state, 1);
        check("tc12_enable", thread_enable, 4'hF);
        check("tc12_busy", busy_cycles, 0);
        start = 1'b0;
        repeat (65540) @(negedge clock);
        check("sat_busy", busy_cycles, 16'hFFFF);
        check("sat_state", core_state, 1);

        // Asynchronous reset mid-WAIT with an LSU busy
        decoded_mem_write = 1'b1;
        lsu_state[1:0]    = 2'b01;
        fetch_ready       = 1'b1;
        wait_state(3'd4, 10, "rst_wait_entry");
        repeat (2) @(negedge clock);
        check("rst_wait_stall", core_state, 4);
        #2 reset = 1'b0;
        #1;
        check("arst_state", core_state, 0);
        check("arst_pc", current_pc, 0);
        check("arst_enable", thread_enable, 0);
        check("arst_busy", busy_cycles, 0);
        check("arst_done", done, 0);
        check("arst_fetch_req", fetch_req, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("arst_idle", core_state, 0);
        decoded_mem_write = 1'b0;
        fetch_ready       = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
